// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: I-cache line geometry and refill FSM types shared across the I-side
package icache_refill_pkg;
    localparam int IC_LINE_WORDS = 4;
    typedef logic [IC_LINE_WORDS*32-1:0] ICData_t;
    typedef enum logic [1:0] {RF_IDLE, RF_ADDR, RF_DATA, RF_FILL} ICRefillState_t;
endpackage

// File: rtl/icache_refill.sv
// icache_refill: fetches one I-cache line as a single incrementing burst and presents it for one cycle
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int WORDS  = IC_LINE_WORDS,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [ADDR_W-1:0]     miss_addr,
    output logic                  miss_ready,
    input  logic                  cancel,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_W-1:0]     ar_addr,
    output logic [7:0]            ar_len,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [31:0]           r_data,
    input  logic                  r_last,
    output logic                  rvalid,
    output logic [WORDS*32-1:0]   rdata,
    output logic                  busy
);
    localparam int CW  = $clog2(WORDS);
    localparam int OFF = CW + 2;
    ICRefillState_t state, state_n;
    logic [CW-1:0] cnt;
    logic dropped;
    logic unused_ok;
    assign unused_ok = ^{r_last, miss_addr[OFF-1:0]};
    assign miss_ready = state == RF_IDLE;
    assign busy = state != RF_IDLE;
    assign ar_valid = state == RF_ADDR;
    assign r_ready = state == RF_DATA;
    assign rvalid = state == RF_FILL && !cancel;
    assign ar_len = 8'(WORDS - 1);
    always_comb begin
        state_n = state;
        unique case (state)
            RF_IDLE: state_n = miss_req ? RF_ADDR : RF_IDLE;
            RF_ADDR: state_n = ar_ready ? RF_DATA : RF_ADDR;
            RF_DATA: state_n = !(r_valid && cnt == CW'(WORDS - 1)) ? RF_DATA :
                               (dropped || cancel) ? RF_IDLE : RF_FILL;
            default: state_n = RF_IDLE;
        endcase
    end
    // A cancelled burst is still drained beat by beat; only the final presentation is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_IDLE;
            cnt     <= '0;
            dropped <= 1'b0;
            ar_addr <= '0;
            rdata   <= '0;
        end else begin
            state <= state_n;
            if (state == RF_IDLE && miss_req) begin
                ar_addr <= {miss_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                cnt     <= '0;
                dropped <= 1'b0;
            end
            if ((state == RF_ADDR || state == RF_DATA) && cancel)
                dropped <= 1'b1;
            if (state == RF_DATA && r_valid) begin
                rdata[32*cnt +: 32] <= r_data;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: table-driven, hand-written and randomized checks of the line refill engine
module tb_icache_refill;
    import icache_refill_pkg::*;
    localparam int WORDS = IC_LINE_WORDS;
    logic clk = 1'b0;
    logic rst, miss_req, cancel, ar_ready, r_valid, r_last;
    logic [31:0] miss_addr, r_data, ar_addr;
    logic miss_ready, ar_valid, r_ready, rvalid, busy;
    logic [7:0] ar_len;
    ICData_t rdata;
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    icache_refill dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .cancel(cancel), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .rvalid(rvalid), .rdata(rdata), .busy(busy)
    );

    typedef struct {
        logic [31:0] addr;
        int          w;
        logic [15:0] vpat;
        int          ca;
        logic [31:0] base;
        logic [31:0] exp_ar;
        int          exp_pulses;
        int          exp_ready;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic int last_beat_slot(input logic [15:0] vpat);
        int n = 0;
        for (int i = 0; i < 16; i++)
            if (vpat[i]) begin
                n++;
                if (n == WORDS) return i;
            end
        return -1;
    endfunction

    function automatic ICData_t model_line(input logic [31:0] base);
        ICData_t l = '0;
        for (int i = 0; i < WORDS; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic int model_ready(input int w, input logic [15:0] vpat, input int ca);
        int j = last_beat_slot(vpat);
        return (ca >= 0 && ca < WORDS) ? 3 + w + j : 4 + w + j;
    endfunction

    // ca: -1 none, 0 while in ADDR, k after k beats, WORDS while presenting the line
    task automatic do_miss(input logic [31:0] addr, input int w, input logic [15:0] vpat, input int ca,
                           input logic [31:0] base, input logic [31:0] exp_ar,
                           output int pulses, output ICData_t line, output int pcyc,
                           output int rcyc, output int beats, output bit ar_ok);
        int arw = 0, vi = 0;
        bit cdone = 0;
        pulses = 0; line = '0; pcyc = -1; rcyc = -1; beats = 0; ar_ok = 1;
        @(negedge clk);
        miss_req = 1; miss_addr = addr;
        @(posedge clk);
        for (int k = 1; k <= 80 && rcyc < 0; k++) begin
            @(negedge clk);
            miss_req = 0;
            ar_ready = ar_valid && arw >= w;
            if (ar_valid) arw++;
            r_valid = r_ready && beats < WORDS && vi < 16 && vpat[vi];
            if (r_ready) vi++;
            r_data = base + 32'(beats);
            r_last = beats == WORDS - 1;
            cancel = !cdone && busy && ca >= 0 && beats == ca;
            if (cancel) cdone = 1;
            #1;
            if (ar_valid && ar_addr !== exp_ar) ar_ok = 0;
            if (r_ready && r_valid) beats++;
            if (rvalid) begin pulses++; line = rdata; pcyc = k; end
            if (miss_ready) rcyc = k;
        end
        cancel = 0; ar_ready = 0; r_valid = 0; r_last = 0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int pulses, pcyc, rcyc, beats;
        ICData_t line;
        bit ar_ok;
        do_miss(v.addr, v.w, v.vpat, v.ca, v.base, v.exp_ar, pulses, line, pcyc, rcyc, beats, ar_ok);
        check({tag, " ar_addr_stable"}, 128'(ar_ok), 128'(1));
        check({tag, " beats"}, 128'(beats), 128'(WORDS));
        check({tag, " rvalid_pulses"}, 128'(pulses), 128'(v.exp_pulses));
        check({tag, " ready_cycle"}, 128'(rcyc), 128'(v.exp_ready));
        if (v.exp_pulses != 0) begin
            check({tag, " rdata"}, line, model_line(v.base));
            check({tag, " rvalid_cycle"}, 128'(pcyc), 128'(v.exp_ready - 1));
        end
    endtask

    initial begin
        vec_t tbl[5];
        vec_t rv;
        int n, pc, c1, c2;
        ICData_t l1, l2;
        logic [31:0] ar2;
        tbl[0] = '{32'h1FC0_0014, 0, 16'hFFFF, -1, 32'h0000_00A0, 32'h1FC0_0010, 1, 7};
        tbl[1] = '{32'h8000_0024, 3, 16'hFF59, -1, 32'h0000_00B0, 32'h8000_0020, 1, 13};
        tbl[2] = '{32'h0000_2008, 0, 16'hFFFF, 1, 32'h0000_00C0, 32'h0000_2000, 0, 6};
        tbl[3] = '{32'h1234_5678, 2, 16'hFFFF, 0, 32'h0000_00D0, 32'h1234_5670, 0, 8};
        tbl[4] = '{32'hABCD_003C, 1, 16'hFFFF, 4, 32'h0000_00E0, 32'hABCD_0030, 0, 8};
        rst = 1; miss_req = 0; miss_addr = '0; cancel = 0; ar_ready = 0;
        r_valid = 0; r_data = '0; r_last = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst miss_ready", 128'(miss_ready), 128'(1));
        check("rst ar_valid", 128'(ar_valid), 128'(0));
        check("rst r_ready", 128'(r_ready), 128'(0));
        check("rst rvalid", 128'(rvalid), 128'(0));
        check("rst busy", 128'(busy), 128'(0));
        check("rst ar_addr", 128'(ar_addr), 128'(0));
        check("rst rdata", rdata, 128'(0));
        check("ar_len", 128'(ar_len), 128'(WORDS - 1));
        for (int i = 0; i < 5; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        @(negedge clk);
        miss_req = 1; miss_addr = 32'h0000_4000;
        @(posedge clk);
        @(negedge clk); miss_req = 0; ar_ready = 1;
        @(negedge clk); ar_ready = 0; r_valid = 1; r_data = 32'h1;
        @(negedge clk); r_data = 32'h2;
        @(negedge clk); r_data = 32'h3; rst = 1;
        @(posedge clk);
        #1;
        rst = 0; r_valid = 0;
        check("midrst busy", 128'(busy), 128'(0));
        check("midrst r_ready", 128'(r_ready), 128'(0));
        check("midrst rvalid", 128'(rvalid), 128'(0));
        check("midrst miss_ready", 128'(miss_ready), 128'(1));
        check("midrst rdata", rdata, 128'(0));
        run_vec("after_rst", '{32'h0000_1000, 0, 16'hFFFF, -1, 32'h0000_0500, 32'h0000_1000, 1, 7});

        n = 0; pc = 0; c1 = -1; c2 = -1; l1 = '0; l2 = '0; ar2 = '0;
        @(negedge clk);
        miss_req = 1; miss_addr = 32'h0000_2200; ar_ready = 1; r_valid = 1; r_data = 32'h100;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            miss_addr = 32'h0000_3304;
            if (k == 8) miss_req = 0;
            r_data = 32'h100 + 32'(n);
            #1;
            if (r_ready && r_valid) n++;
            if (ar_valid && ar_ready && k > 1) ar2 = ar_addr;
            if (rvalid) begin
                if (pc == 0) begin c1 = k; l1 = rdata; end
                else begin c2 = k; l2 = rdata; end
                pc++;
            end
        end
        miss_req = 0; ar_ready = 0; r_valid = 0;
        check("b2b pulses", 128'(pc), 128'(2));
        check("b2b first_cycle", 128'(c1), 128'(6));
        check("b2b second_cycle", 128'(c2), 128'(13));
        check("b2b first_line", l1, model_line(32'h100));
        check("b2b second_line", l2, model_line(32'h104));
        check("b2b second_ar_addr", 128'(ar2), 128'(32'h0000_3300));

        for (int i = 0; i < 24; i++) begin
            rv.addr = $urandom;
            rv.w = int'($urandom_range(0, 3));
            rv.vpat = 16'($urandom) | 16'hF000;
            rv.ca = int'($urandom_range(0, 8)) - 4;
            if (rv.ca < 0) rv.ca = -1;
            rv.base = $urandom;
            rv.exp_ar = rv.addr & ~32'(WORDS * 4 - 1);
            rv.exp_pulses = rv.ca < 0 ? 1 : 0;
            rv.exp_ready = model_ready(rv.w, rv.vpat, rv.ca);
            run_vec($sformatf("rand%0d", i), rv);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
